multi_mode_led_sequencer: RTL

Parametrised successor to the two-switch selective blinker. It drives NUM_LEDS LED outputs from a channel-select bus and a 2-bit mode bus. Modes are off, solid, blink and chase, all timed from a shared COUNT-cycle tick. It sits between the board switch inputs and the LED pins in the top level.

---
 rtl/multi_mode_led_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/multi_mode_led_sequencer.sv
// multi_mode_led_sequencer: drives NUM_LEDS LEDs in OFF / SOLID / BLINK / CHASE modes from
// synchronized switch inputs. Define DEBOUNCE_EN to add a stability filter in front of the commit stage.
module multi_mode_led_sequencer #(
    parameter int NUM_LEDS       = 4,
    parameter int SEL_WIDTH      = $clog2(NUM_LEDS),
    parameter int COUNT          = 25000000,
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic [SEL_WIDTH-1:0] i_Sel,
    input  logic [1:0]           i_Mode,
    output logic [NUM_LEDS-1:0]  o_LED,
    output logic                 o_Phase,
    output logic                 o_Cfg_Change
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_CHASE = 2'd3
    } mode_t;

    localparam int CFG_W = SEL_WIDTH + 2;
    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(COUNT - 1);
    localparam logic [SEL_WIDTH-1:0] POS_LAST = SEL_WIDTH'(NUM_LEDS - 1);

    logic [CFG_W-1:0]     sync1, sync2, cfg;
    logic                 commit;
    logic [CNT_W-1:0]     tick_cnt;
    logic                 tick, phase;
    logic [SEL_WIDTH-1:0] chase_pos;
    logic [SEL_WIDTH-1:0] cfg_sel;
    mode_t                cfg_mode;
    logic [NUM_LEDS-1:0]  led_next;

    // Config word is {sel, mode}.
    assign cfg_sel  = cfg[CFG_W-1:2];
    assign cfg_mode = mode_t'(cfg[1:0]);

    function automatic logic [NUM_LEDS-1:0] one_hot(input logic [SEL_WIDTH-1:0] idx);
        one_hot = '0;
        for (int i = 0; i < NUM_LEDS; i++) one_hot[i] = (idx == SEL_WIDTH'(i));
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {i_Sel, i_Mode};
            sync2 <= sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);

    logic [CFG_W-1:0] sync_prev;
    logic [DB_W-1:0]  stable_cnt;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_prev  <= '0;
            stable_cnt <= '0;
        end else begin
            sync_prev <= sync2;
            if (sync2 != sync_prev)
                stable_cnt <= '0;
            else if (stable_cnt != DB_LAST)
                stable_cnt <= stable_cnt + 1'b1;
        end
    end

    // Saturated counter plus a stable current cycle means DEBOUNCE_LIMIT unchanged cycles.
    assign commit = (sync2 == sync_prev) && (stable_cnt == DB_LAST) && (sync2 != cfg);
`else
    assign commit = (sync2 != cfg);
`endif

    assign tick = (tick_cnt == CNT_LAST);

    // A commit restarts the timebase and takes priority over a coincident tick.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cfg          <= '0;
            tick_cnt     <= '0;
            phase        <= 1'b0;
            chase_pos    <= '0;
            o_Cfg_Change <= 1'b0;
        end else begin
            o_Cfg_Change <= commit;
            if (commit) begin
                cfg       <= sync2;
                tick_cnt  <= '0;
                phase     <= 1'b1;
                chase_pos <= '0;
            end else if (tick) begin
                tick_cnt  <= '0;
                phase     <= ~phase;
                chase_pos <= (chase_pos == POS_LAST) ? '0 : chase_pos + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns led_next and no latch is inferred.
        led_next = '0;
        unique case (cfg_mode)
            MODE_SOLID: led_next = one_hot(cfg_sel);
            MODE_BLINK: led_next = phase ? one_hot(cfg_sel) : '0;
            MODE_CHASE: led_next = one_hot(chase_pos);
            default:    led_next = '0;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)
            o_LED <= '0;
        else
            o_LED <= led_next;
    end

    assign o_Phase = phase;

endmodule
